// File: rtl/us128_line_doubler_if.sv
// rtl/us128_line_doubler_if.sv - pixel in/out stream bundle for the 2x line doubler
interface us128_line_doubler_if #(
  parameter int DW = 8
);
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_sol;
  logic          dout_eol;
  logic          dout_pass;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_sol, dout_eol, dout_pass
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_sol, dout_eol, dout_pass
  );
endinterface

// File: rtl/us128_line_doubler.sv
// rtl/us128_line_doubler.sv - 2x raster upscaler: buffers one line, emits it twice with
// horizontal midpoint interpolation (rounded) and edge replication.
module us128_line_doubler #(
  parameter int DW   = 8,
  parameter int IN_W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  us128_line_doubler_if.slave   bus
);
  localparam int AW = $clog2(IN_W);
  localparam int XW = AW + 1;
  localparam logic [AW-1:0] WI_LAST = AW'(IN_W - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(2 * IN_W - 1);

  // DRAIN: every pixel is in or past the output register; wait for the last handoff.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    EMIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [DW-1:0]  line_buf [IN_W];
  logic [AW-1:0]  wi;
  logic [XW-1:0]  x;
  logic           pass;

  logic           ready_c;
  logic           load_pix;
  logic           clear_out;
  logic           in_fire;
  logic           out_free;

  logic [AW-1:0]  k;
  logic [AW-1:0]  kn;
  logic [DW-1:0]  pa;
  logic [DW-1:0]  pb;
  logic [DW:0]    sum;
  logic [DW-1:0]  pix;

  assign in_fire   = bus.din_valid && ready_c;
  assign out_free  = !bus.dout_valid || bus.dout_ready;
  assign bus.din_ready = ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    load_pix  = 1'b0;
    clear_out = 1'b0;
    unique case (state)
      LOAD: begin
        ready_c = 1'b1;
        if (bus.din_valid && (wi == WI_LAST)) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_free) begin
          load_pix = 1'b1;
          if ((x == X_LAST) && pass) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.dout_valid && bus.dout_ready) begin
          clear_out = 1'b1;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Line storage is never observed before it is rewritten, so it carries no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      line_buf[wi] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wi <= '0;
    end else if (in_fire) begin
      wi <= wi + 1'b1;
    end
  end

  // After the pass-1 end pixel, x/pass wrap to 0/0, ready for the next line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      pass <= 1'b0;
    end else if (load_pix) begin
      if (x == X_LAST) begin
        x    <= '0;
        pass <= !pass;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign k   = x[XW-1:1];
  assign kn  = k + 1'b1;
  assign pa  = line_buf[k];
  assign pb  = line_buf[kn];
  assign sum = {1'b0, pa} + {1'b0, pb} + {{DW{1'b0}}, 1'b1};

  always_comb begin
    pix = pa;
    if (x[0] && (k != WI_LAST)) begin
      pix = sum[DW:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.dout_sol   <= 1'b0;
      bus.dout_eol   <= 1'b0;
      bus.dout_pass  <= 1'b0;
    end else if (load_pix) begin
      bus.dout       <= pix;
      bus.dout_valid <= 1'b1;
      bus.dout_sol   <= (x == '0);
      bus.dout_eol   <= (x == X_LAST);
      bus.dout_pass  <= pass;
    end else if (clear_out) begin
      bus.dout_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_us128_line_doubler.sv
// tb/tb_us128_line_doubler.sv - directed bench for us128_line_doubler with output scoreboard
module tb_us128_line_doubler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  us128_line_doubler_if #(.DW(8)) bus ();

  us128_line_doubler #(.DW(8), .IN_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard entry: [10]=pass [9]=sol [8]=eol [7:0]=pixel
  logic [10:0] exp_q [$];
  logic [7:0]  line_px [128];
  logic [7:0]  got0 [256];
  int          out_count;
  int          run;
  int          max_run;
  int          ready_mode;
  logic        stalled_prev;
  logic        last_seen;
  logic [10:0] prev_out;

  function automatic logic [7:0] model_pix(input int xo);
    int kk;
    int v;
    kk = xo / 2;
    if ((xo % 2) == 0 || kk == 127) v = int'(line_px[kk]);
    else v = (int'(line_px[kk]) + int'(line_px[kk + 1]) + 1) / 2;
    return 8'(v);
  endfunction

  task automatic push_expected();
    for (int p = 0; p < 2; p++) begin
      for (int xo = 0; xo < 256; xo++) begin
        exp_q.push_back({p[0], (xo == 0), (xo == 255), model_pix(xo)});
      end
    end
  endtask

  always @(negedge clk) begin
    logic [10:0] cur;
    logic [10:0] e;
    if (!rst_n) begin
      stalled_prev = 1'b0;
      run = 0;
    end else begin
      cur = {bus.dout_pass, bus.dout_sol, bus.dout_eol, bus.dout};
      if (stalled_prev) check("hold_stable", 32'(cur), 32'(prev_out));
      if (bus.dout_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'(cur), 32'(e));
        end
        if (out_count < 256) got0[out_count] = bus.dout;
        out_count++;
        if (cur[10] && cur[8]) last_seen = 1'b1;
      end
      stalled_prev = bus.dout_valid && !bus.dout_ready;
      prev_out = cur;
    end
  end

  always @(posedge clk) begin
    #1;
    bus.dout_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (last_seen) begin
      last_seen = 1'b0;
      check("din_ready_at_M", 32'(bus.din_ready), 32'd1);
      check("valid_fall_M", 32'(bus.dout_valid), 32'd0);
    end
  end

  task automatic send_px(input logic [7:0] v, input int gap);
    int n;
    n = 0;
    bus.din = v;
    bus.din_valid = 1'b1;
    while (!bus.din_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("din_ready_wait", 32'(bus.din_ready), 32'd1);
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_line(input int gap);
    for (int i = 0; i < 128; i++) send_px(line_px[i], gap);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.dout_valid), 32'd0);
    check({tag, "_dout"}, 32'(bus.dout), 32'd0);
    check({tag, "_side"}, 32'({bus.dout_sol, bus.dout_eol, bus.dout_pass}), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    exp_q.delete();
    last_seen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_din_ready", 32'(bus.din_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b1;
    ready_mode = 0;
    out_count = 0;
    max_run = 0;
    run = 0;
    last_seen = 1'b0;
    stalled_prev = 1'b0;
    #1;
    check_reset_outputs("init");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("init_din_ready", 32'(bus.din_ready), 32'd1);

    // Ramp with latency checks
    for (int i = 0; i < 128; i++) line_px[i] = 8'(2 * i);
    push_expected();
    out_count = 0;
    max_run = 0;
    for (int i = 0; i < 127; i++) send_px(line_px[i], 0);
    bus.din = line_px[127];
    bus.din_valid = 1'b1;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    check("lat_N_valid", 32'(bus.dout_valid), 32'd0);
    check("lat_N_din_ready", 32'(bus.din_ready), 32'd0);
    @(posedge clk); #1;
    check("lat_N1_valid", 32'(bus.dout_valid), 32'd1);
    check("lat_N1_sol", 32'({bus.dout_sol, bus.dout_pass}), 32'd2);
    wait_drain();
    check("ramp_contig", 32'(max_run), 32'd512);
    check("ramp_x1", 32'(got0[1]), 32'd1);
    check("ramp_x100", 32'(got0[100]), 32'd100);
    check("ramp_x253", 32'(got0[253]), 32'd253);
    check("ramp_x254", 32'(got0[254]), 32'd254);
    check("ramp_x255", 32'(got0[255]), 32'd254);

    // Rounding and width
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 128; i++) line_px[i] = 8'd10;
      case (t)
        0: begin line_px[0] = 8'd0;   line_px[1] = 8'd1;   end
        1: begin line_px[0] = 8'd255; line_px[1] = 8'd255; end
        default: begin line_px[0] = 8'd255; line_px[1] = 8'd0; end
      endcase
      push_expected();
      out_count = 0;
      send_line(0);
      wait_drain();
      case (t)
        0: check("round_0_1", 32'(got0[1]), 32'd1);
        1: check("round_255_255", 32'(got0[1]), 32'd255);
        default: check("round_255_0", 32'(got0[1]), 32'd128);
      endcase
    end

    // Backpressure across two lines
    ready_mode = 1;
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 128; i++) line_px[i] = 8'($urandom_range(0, 255));
      push_expected();
      send_line(0);
    end
    wait_drain();
    ready_mode = 0;

    // Input gaps, then din_valid held high during EMIT
    for (int i = 0; i < 128; i++) line_px[i] = 8'(3 * i + 7);
    push_expected();
    send_line(2);
    bus.din = 8'hAA;
    bus.din_valid = 1'b1;
    repeat (50) begin @(posedge clk); #1; end
    check("emit_din_ready", 32'(bus.din_ready), 32'd0);
    repeat (50) begin @(posedge clk); #1; end
    bus.din_valid = 1'b0;
    wait_drain();

    // Reset at input pixel 60
    for (int i = 0; i < 60; i++) send_px(8'(i + 100), 0);
    #2;
    do_reset();
    for (int i = 0; i < 128; i++) line_px[i] = 8'(255 - i);
    push_expected();
    send_line(0);
    wait_drain();

    // Reset at output pass 1, x = 100
    for (int i = 0; i < 128; i++) line_px[i] = 8'($urandom_range(0, 255));
    push_expected();
    out_count = 0;
    send_line(0);
    n = 0;
    while (out_count < 356 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_p1_x100", 32'(out_count >= 356), 32'd1);
    do_reset();
    for (int i = 0; i < 128; i++) line_px[i] = 8'(i ^ 8'h5A);
    push_expected();
    send_line(0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
